// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: SPI NOR opcodes and writer state encoding
package spi_flash_pkg;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_SE4K  = 8'h20;
  localparam logic [7:0] OP_PP    = 8'h02;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_DUMMY = 8'hFF;
  typedef enum logic [3:0] {
    S_IDLE, S_GAP, S_WREN, S_CMD, S_ADDR2, S_ADDR1, S_ADDR0,
    S_FETCH, S_PROG, S_POLL_CMD, S_POLL_RD, S_DONE
  } state_t;
endpackage

// File: rtl/toggle_hs.sv
// toggle_hs: req/ack toggle handshake; done strobes while ack matches an outstanding req
module toggle_hs (
  input  logic clk,
  input  logic rst,
  input  logic go_i,
  input  logic ack_i,
  output logic req_o,
  output logic done_o
);
  logic req_q, pend_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q  <= 1'b0;
      pend_q <= 1'b0;
    end else if (go_i) begin
      req_q  <= ~req_q;
      pend_q <= 1'b1;
    end else if (done_o) begin
      pend_q <= 1'b0;
    end
  end
  assign req_o  = req_q;
  assign done_o = pend_q && (ack_i == req_q);
endmodule

// File: rtl/chameleon_spi_flash_writer.sv
// chameleon_spi_flash_writer: erases 4K sectors and page-programs SPI NOR flash from a byte source
module chameleon_spi_flash_writer
  import spi_flash_pkg::*;
#(
  parameter int a_bits     = 14,
  parameter int cs_gap     = 8,
  parameter int poll_limit = 2**20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [23:0]       flash_addr,
  input  logic [15:0]       amount,
  output logic              busy,
  output logic              error,
  output logic              cs_n,
  output logic              spi_req,
  input  logic              spi_ack,
  output logic [7:0]        spi_d,
  input  logic [7:0]        spi_q,
  output logic              src_req,
  input  logic              src_ack,
  output logic [a_bits-1:0] src_a,
  input  logic [7:0]        src_q
);
  state_t state_q, nxt_q;
  logic [23:0] addr_q;
  logic [15:0] remain_q;
  logic [a_bits-1:0] src_a_q;
  logic [31:0] cnt_q;
  logic [7:0] spi_d_q, data_q, tx;
  logic busy_q, error_q, cs_n_q, sent_q, erase_q, spi_go_q, src_go_q;
  logic spi_done, src_done, byte_st, unused_q;
  toggle_hs u_spi (.clk(clk), .rst(reset), .go_i(spi_go_q), .ack_i(spi_ack), .req_o(spi_req), .done_o(spi_done));
  toggle_hs u_src (.clk(clk), .rst(reset), .go_i(src_go_q), .ack_i(src_ack), .req_o(src_req), .done_o(src_done));
  always_comb begin
    tx = OP_DUMMY;
    byte_st = 1'b1;
    case (state_q)
      S_WREN:     tx = OP_WREN;
      S_CMD:      tx = erase_q ? OP_SE4K : OP_PP;
      S_ADDR2:    tx = addr_q[23:16];
      S_ADDR1:    tx = addr_q[15:8];
      S_ADDR0:    tx = addr_q[7:0];
      S_PROG:     tx = data_q;
      S_POLL_CMD: tx = OP_RDSR;
      S_POLL_RD:  tx = OP_DUMMY;
      default:    byte_st = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    spi_go_q <= 1'b0;
    src_go_q <= 1'b0;
    if (reset) begin
      state_q  <= S_IDLE;
      nxt_q    <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      src_a_q  <= '0;
      cnt_q    <= '0;
      spi_d_q  <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
      cs_n_q   <= 1'b1;
      sent_q   <= 1'b0;
      erase_q  <= 1'b0;
    end else begin
      // every byte state launches its byte once, then waits for the matching ack
      if (byte_st && !sent_q) begin
        spi_d_q  <= tx;
        spi_go_q <= 1'b1;
        sent_q   <= 1'b1;
      end
      case (state_q)
        S_IDLE: if (start) begin
          addr_q   <= flash_addr;
          remain_q <= amount;
          src_a_q  <= '0;
          error_q  <= 1'b0;
          busy_q   <= 1'b1;
          erase_q  <= 1'b1;
          cnt_q    <= '0;
          nxt_q    <= S_WREN;
          state_q  <= (amount == 16'd0) ? S_DONE : S_GAP;
        end
        S_GAP: if (cnt_q + 32'd1 >= 32'(cs_gap)) begin
          cs_n_q  <= 1'b0;
          state_q <= nxt_q;
        end else cnt_q <= cnt_q + 32'd1;
        S_WREN: if (spi_done) begin
          sent_q  <= 1'b0;
          cs_n_q  <= 1'b1;
          cnt_q   <= '0;
          nxt_q   <= S_CMD;
          state_q <= S_GAP;
        end
        S_CMD:   if (spi_done) begin sent_q <= 1'b0; state_q <= S_ADDR2; end
        S_ADDR2: if (spi_done) begin sent_q <= 1'b0; state_q <= S_ADDR1; end
        S_ADDR1: if (spi_done) begin sent_q <= 1'b0; state_q <= S_ADDR0; end
        S_ADDR0: if (spi_done) begin
          sent_q <= 1'b0;
          if (erase_q) begin
            cs_n_q  <= 1'b1;
            cnt_q   <= '0;
            nxt_q   <= S_POLL_CMD;
            state_q <= S_GAP;
          end else state_q <= S_FETCH;
        end
        S_FETCH: if (!sent_q) begin
          src_go_q <= 1'b1;
          sent_q   <= 1'b1;
        end else if (src_done) begin
          data_q  <= src_q;
          sent_q  <= 1'b0;
          state_q <= S_PROG;
        end
        S_PROG: if (spi_done) begin
          sent_q   <= 1'b0;
          addr_q   <= addr_q + 24'd1;
          src_a_q  <= src_a_q + a_bits'(1);
          remain_q <= remain_q - 16'd1;
          if (remain_q == 16'd1 || addr_q[7:0] == 8'hFF) begin
            cs_n_q  <= 1'b1;
            cnt_q   <= '0;
            nxt_q   <= S_POLL_CMD;
            state_q <= S_GAP;
          end else state_q <= S_FETCH;
        end
        S_POLL_CMD: if (spi_done) begin sent_q <= 1'b0; cnt_q <= '0; state_q <= S_POLL_RD; end
        S_POLL_RD: if (spi_done) begin
          sent_q <= 1'b0;
          cnt_q  <= cnt_q + 32'd1;
          // after an erase the page program follows; after a program a new sector needs erasing first
          if (!spi_q[0]) begin
            cs_n_q  <= 1'b1;
            cnt_q   <= '0;
            erase_q <= !erase_q && addr_q[11:0] == 12'd0;
            nxt_q   <= S_WREN;
            state_q <= (!erase_q && remain_q == 16'd0) ? S_DONE : S_GAP;
          end else if (cnt_q + 32'd1 > 32'(poll_limit)) begin
            cs_n_q  <= 1'b1;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_DONE: begin busy_q <= 1'b0; state_q <= S_IDLE; end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign unused_q = ^spi_q[7:1];
  assign busy  = busy_q;
  assign error = error_q;
  assign cs_n  = cs_n_q;
  assign spi_d = spi_d_q;
  assign src_a = src_a_q;
endmodule

// File: tb/tb_chameleon_spi_flash_writer.sv
// tb_chameleon_spi_flash_writer: flash/source models plus a frame-level reference of the programming sequence
module tb_chameleon_spi_flash_writer;
  localparam int AB = 14, GAP = 4, PL = 1024;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [23:0] flash_addr = '0;
  logic [15:0] amount = '0;
  logic busy, error, cs_n, spi_req, spi_ack, src_req, src_ack;
  logic [7:0] spi_d, spi_q, src_q;
  logic [AB-1:0] src_a;
  logic [7:0] mem [0:(1<<AB)-1];
  logic [7:0] got_b[$], exp_b[$];
  int got_len[$], exp_len[$], got_src[$], exp_src[$];
  int cur_len, open_len, wip_n, proto_err, n_tog, n_chk, n_fail;
  logic [7:0] first_b;
  logic cs_prev;
  typedef struct { logic [23:0] a; int n; int wip; int er; int pp; } vec_t;
  vec_t vt[6];

  always #5 clk = ~clk;

  chameleon_spi_flash_writer #(.a_bits(AB), .cs_gap(GAP), .poll_limit(PL)) dut (
    .clk(clk), .reset(reset), .start(start), .flash_addr(flash_addr), .amount(amount),
    .busy(busy), .error(error), .cs_n(cs_n), .spi_req(spi_req), .spi_ack(spi_ack),
    .spi_d(spi_d), .spi_q(spi_q), .src_req(src_req), .src_ack(src_ack), .src_a(src_a), .src_q(src_q));

  // flash model: records each chip-select frame, reports WIP for the first wip_n status reads of a frame
  always @(posedge clk) begin
    if (reset) begin
      spi_ack <= 1'b0;
      spi_q <= 8'h00;
      cur_len = 0;
      cs_prev = 1'b1;
    end else begin
      if (cs_n !== cs_prev && spi_req !== spi_ack) proto_err++;
      if (spi_req !== spi_ack && $urandom_range(0, 1) == 0) begin
        if (cs_n) proto_err++;
        if (cur_len == 0) first_b = spi_d;
        spi_q <= {7'd0, first_b == 8'h05 && cur_len >= 1 && cur_len <= wip_n};
        got_b.push_back(spi_d);
        cur_len++;
        n_tog++;
        spi_ack <= spi_req;
      end
      if (cs_n && cur_len != 0) begin
        got_len.push_back(cur_len);
        cur_len = 0;
      end
      cs_prev = cs_n;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      src_ack <= 1'b0;
      src_q <= 8'h00;
    end else if (src_req !== src_ack && $urandom_range(0, 1) == 0) begin
      src_q <= mem[src_a];
      got_src.push_back(int'(src_a));
      src_ack <= src_req;
    end
  end

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic eb(input logic [7:0] b);
    exp_b.push_back(b);
    open_len++;
  endtask

  task automatic ef();
    exp_len.push_back(open_len);
    open_len = 0;
  endtask

  task automatic poll(input int wip);
    eb(8'h05);
    for (int i = 0; i <= wip; i++) eb(8'hFF);
    ef();
  endtask

  // reference: split the job into page-sized chunks, erasing at the start and at each new 4K sector
  task automatic model(input logic [23:0] a0, input int n0, input int wip);
    logic [23:0] a;
    int n, s, k;
    bit er;
    a = a0; n = n0; s = 0; er = 1'b1;
    exp_b.delete(); exp_len.delete(); exp_src.delete(); open_len = 0;
    while (n > 0) begin
      if (er) begin
        eb(8'h06); ef();
        eb(8'h20); eb(a[23:16]); eb(a[15:8]); eb(a[7:0]); ef();
        poll(wip);
      end
      eb(8'h06); ef();
      eb(8'h02); eb(a[23:16]); eb(a[15:8]); eb(a[7:0]);
      k = 256 - (int'(a) % 256);
      if (k > n) k = n;
      for (int i = 0; i < k; i++) begin
        eb(mem[(s + i) % (1 << AB)]);
        exp_src.push_back((s + i) % (1 << AB));
      end
      ef();
      poll(wip);
      a = a + 24'(k); s += k; n -= k;
      er = (int'(a) % 4096 == 0);
    end
  endtask

  function automatic int byte_diff();
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++)
      if (got_b[i] !== exp_b[i]) return i;
    return (got_b.size() == exp_b.size()) ? -1 : ((got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size());
  endfunction

  function automatic int len_diff();
    for (int i = 0; i < got_len.size() && i < exp_len.size(); i++)
      if (got_len[i] != exp_len[i]) return i;
    return (got_len.size() == exp_len.size()) ? -1 : -2;
  endfunction

  function automatic int src_diff();
    for (int i = 0; i < got_src.size() && i < exp_src.size(); i++)
      if (got_src[i] != exp_src[i]) return i;
    return (got_src.size() == exp_src.size()) ? -1 : -2;
  endfunction

  task automatic clear();
    got_b.delete(); got_len.delete(); got_src.delete();
    n_tog = 0; proto_err = 0;
  endtask

  task automatic start_job(input logic [23:0] a, input int n);
    flash_addr = a; amount = 16'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (busy && c < 40000) begin @(negedge clk); c++; end
    check("busy_falls", busy, 0);
  endtask

  task automatic check_reset(input string nm);
    check({nm, " busy"}, busy, 0);
    check({nm, " error"}, error, 0);
    check({nm, " cs_n"}, cs_n, 1);
    check({nm, " spi_req"}, spi_req, 0);
    check({nm, " src_req"}, src_req, 0);
    check({nm, " spi_d"}, spi_d, 0);
    check({nm, " src_a"}, src_a, 0);
  endtask

  task automatic run_check(input string nm, input logic [23:0] a, input int n, input int wip, input int ex_er, input int ex_pp);
    int p, ne, np;
    clear(); wip_n = wip; model(a, n, wip);
    start_job(a, n);
    check({nm, " busy_rise"}, busy, 1);
    wait_done();
    repeat (3) @(negedge clk);
    check({nm, " error"}, error, 0);
    check({nm, " frame_count"}, got_len.size(), exp_len.size());
    check({nm, " frame_len_diff"}, len_diff(), -1);
    check({nm, " byte_diff"}, byte_diff(), -1);
    check({nm, " src_a_diff"}, src_diff(), -1);
    check({nm, " protocol"}, proto_err, 0);
    if (ex_er >= 0) begin
      p = 0; ne = 0; np = 0;
      foreach (got_len[f]) begin
        if (p < got_b.size() && got_b[p] == 8'h20) ne++;
        if (p < got_b.size() && got_b[p] == 8'h02) np++;
        p += got_len[f];
      end
      check({nm, " erases"}, ne, ex_er);
      check({nm, " programs"}, np, ex_pp);
    end
  endtask

  initial begin
    int bc, c;
    n_chk = 0; n_fail = 0; wip_n = 0;
    for (int i = 0; i < (1 << AB); i++) mem[i] = 8'($urandom);
    vt[0] = '{24'h010000, 256, 0, 1, 1};
    vt[1] = '{24'h0000F0, 32, 2, 1, 2};
    vt[2] = '{24'h000F00, 512, 1, 2, 2};
    vt[3] = '{24'h020000, 5, 1000, 1, 1};
    vt[4] = '{24'hFFFFF8, 16, 0, 2, 2};
    vt[5] = '{24'h000123, 1, 3, 1, 1};
    clear();
    repeat (3) @(negedge clk);
    check_reset("reset");
    reset = 1'b0;
    @(negedge clk);
    for (int v = 0; v < 6; v++) run_check($sformatf("vec%0d", v), vt[v].a, vt[v].n, vt[v].wip, vt[v].er, vt[v].pp);
    for (int r = 0; r < 4; r++)
      run_check($sformatf("rand%0d", r), 24'($urandom), int'($urandom_range(1, 300)), int'($urandom_range(0, 3)), -1, -1);

    clear();
    start_job(24'h000100, 0);
    bc = 0;
    repeat (10) begin if (busy) bc++; @(negedge clk); end
    check("zero busy_cycles", bc, 1);
    check("zero spi_toggles", n_tog, 0);

    clear(); wip_n = 1; model(24'h040000, 40, 1);
    start_job(24'h040000, 40);
    repeat (30) @(negedge clk);
    start_job(24'h050000, 7);
    wait_done();
    repeat (3) @(negedge clk);
    check("ignored_start byte_diff", byte_diff(), -1);
    check("ignored_start frame_count", got_len.size(), exp_len.size());

    clear(); wip_n = 1 << 30;
    start_job(24'h030000, 4);
    wait_done();
    check("timeout error", error, 1);
    check("timeout cs_n", cs_n, 1);
    repeat (3) @(negedge clk);
    check("timeout frame_count", got_len.size(), 3);
    check("timeout poll_len", got_len.size() > 2 ? got_len[2] : -1, PL + 2);
    clear(); wip_n = 0; model(24'h030000, 1, 0);
    start_job(24'h030000, 1);
    check("restart error_cleared", error, 0);
    wait_done();
    repeat (3) @(negedge clk);
    check("restart byte_diff", byte_diff(), -1);

    clear();
    start_job(24'h060000, 300);
    c = 0;
    while (got_b.size() <= 30 && c < 5000) begin @(negedge clk); c++; end
    check("midreset reached_pp", got_b.size() > 30, 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset("midreset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/chameleon_spi_flash_writer.md
# chameleon_spi_flash_writer

Programs the on-board SPI NOR flash from a byte source, the write-side counterpart of the flash loader. It uses the shared chameleon2_spi byte master through the same toggle req/ack port that the loader drives, muxed by the top level. For each 4 KiB sector touched it issues WREN + sector erase. It then writes the data as WREN + page-program bursts and polls the status register after every erase and program. Byte data is pulled from a memory (cart BRAM or SDRAM front-end) over a toggle handshake.

## Interface
- a_bits, 14: source address width.
- cs_gap, 8: minimum clk cycles cs_n stays high between commands.
- poll_limit, 2**20: maximum status reads per busy-wait before error.
- clk  in  1  system clock (sysclk); one clock domain.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; sampled only when busy=0.
- flash_addr  in  24  first flash byte address.
- amount  in  16  byte count to program.
- busy  out  1  high from the cycle after accepted start until done or error.
- error  out  1  sticky poll timeout flag; cleared by next accepted start.
- cs_n  out  1  flash chip select.
- spi_req  out  1  toggle per byte exchange.
- spi_ack  in  1  equals spi_req when exchange complete.
- spi_d  out  8  byte to shift out.
- spi_q  in  8  byte shifted in, valid when spi_ack==spi_req.
- src_req  out  1  toggle per source read.
- src_ack  in  1  equals src_req when src_q valid.
- src_a  out  a_bits  source byte address.
- src_q  in  8  source data.

## Operation
- Reset values: busy=0, error=0, cs_n=1, spi_req=0, src_req=0, spi_d=8'h00, src_a=0. The SPI master and source are reset by the same reset, so req==ack afterwards.
- Accepted start latches flash_addr into addr (24 bits), amount into remain (16 bits), and sets src_a=0 and error=0. If amount=0: busy high for exactly one cycle, no SPI traffic.
- States: IDLE, GAP, WREN, CMD, ADDR2, ADDR1, ADDR0, FETCH, PROG, POLL_CMD, POLL_RD, DONE.
- Each command frame:
  - GAP holds cs_n=1 for cs_gap cycles, then asserts cs_n=0.
  - Bytes are sent one at a time. Frames end by raising cs_n the cycle after the last ack.
- Sequence per sector: WREN (8'h06) frame, then 8'h20 + addr[23:16], addr[15:8], addr[7:0], then poll.
- Erase is issued when the phase is first entered after start, and whenever addr[11:0]==0 on a page boundary with remain>0.
- Page program: WREN frame, then 8'h02 + 3 address bytes. For each byte:
  - FETCH toggles src_req and waits for src_ack==src_req.
  - PROG sends src_q.
  - Then addr+1, src_a+1 (wraps mod 2**a_bits), remain-1.
- The burst closes when remain hits 0 or addr[7:0] wraps to 0. Then poll.
- Poll: 8'h05 in POLL_CMD, then POLL_RD sends 8'hFF repeatedly with cs_n held low until spi_q[0]==0. Then raise cs_n and continue.
- A count of status reads above poll_limit sets error=1 and cs_n=1, then goes to IDLE (busy=0).
- After the final poll, DONE drops busy the next cycle.
- addr wraps 24'hFFFFFF→0 with no special handling.
- start while busy=1 is ignored.
- Reset mid-operation: next-cycle outputs equal reset values; the flash contents in progress are undefined.

## Timing
- At most one outstanding spi or src toggle.
- spi_d is stable from the toggle cycle until ack. src_a is stable from the src_req toggle until ack.
- spi_q and src_q are captured in the cycle ack matches; the next toggle can occur no earlier than the following cycle.
- cs_n changes only while no SPI exchange is outstanding.
- busy rises 1 cycle after start; first spi_req toggle ≥ cs_gap+1 cycles after start.

## Structure
- Shared package spi_flash_pkg: opcode constants (WREN 8'h06, SE4K 8'h20, PP 8'h02, RDSR 8'h05, DUMMY 8'hFF), state encoding.
- One natural sub-module, toggle_hs: req/ack toggle generator with done strobe, instantiated twice (spi, src).

## Test plan
- **Single page:** flash_addr=24'h010000, amount=256. Required frames: WREN; 20 01 00 00; poll; WREN; 02 01 00 00 + 256 bytes matching src[0..255]; poll; busy falls; error=0.
- **Page straddle:** flash_addr=24'h0000F0, amount=32. Required: one erase at 000000, then a PP of 16 bytes at 0000F0 and a PP of 16 bytes at 000100; src_a runs 0..31.
- **Sector cross:** flash_addr=24'h000F00, amount=512. Required: erase 000000; PP 000F00; erase 001000; PP 001000.
- **Poll wait:** flash model reports WIP for 1000 reads. Required: cs_n stays low across all 1001 RDSR data bytes; the writer proceeds only after spi_q[0]=0.
- **Timeout and restart:** poll_limit=16, WIP stuck. Required: error=1, busy=0, cs_n=1 after the 17th read. A new start clears error.
- **Edge cases:** amount=0 gives a one-cycle busy pulse and zero spi toggles. Reset asserted mid-PP gives cs_n=1 and all outputs at reset values next cycle. start during busy is ignored.
